// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester byte FIFO feeding a UART TX launch sequencer with a drain interrupt
// Ports:
//   clock, Rst             system clock, async active-high reset
//   req_valid/req_ready    per-requester handshake (0 = CPU, 1 = debug)
//   req_data0/req_data1    requester bytes
//   tx_start/tx_data       one-cycle launch pulse and registered byte to the TX engine
//   tx_busy                TX engine busy status
//   irq_en/irq_clr/irq     sticky drain interrupt with enable and clear
//   fifo_count             FIFO occupancy
module uart_tx_sched #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     Rst,
  input  logic [1:0]               req_valid,
  input  logic [7:0]               req_data0,
  input  logic [7:0]               req_data1,
  output logic [1:0]               req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     irq_en,
  input  logic                     irq_clr,
  output logic                     irq,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic last_grant, full, push, pop, irq_set;
  logic [7:0] push_data;
  assign full = fifo_count == (AW+1)'(DEPTH);
  // On a tie the requester that did not win the last accepted push is granted.
  always_comb begin
    req_ready = 2'b00;
    if (!Rst && !full) req_ready = (req_valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
  end
  assign push      = |(req_valid & req_ready);
  assign push_data = req_ready[1] ? req_data1 : req_data0;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  // No pop happens in WAIT_DONE, so the FIFO is empty after the edge only if it is empty now and nothing is pushed.
  assign irq_set   = (state == WAIT_DONE) && !tx_busy && irq_en && (fifo_count == '0) && !push;
  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      IDLE:      state_nx = pop ? LAUNCH : IDLE;
      LAUNCH:    begin
        tx_start = 1'b1;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: state_nx = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_nx = tx_busy ? WAIT_DONE : IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_data    <= 8'h00;
      irq        <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      state      <= state_nx;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      irq        <= irq_set | (irq & ~irq_clr);
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= req_ready[1];
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and random checks of uart_tx_sched against a queue-based reference model
module tb_uart_tx_sched;
  localparam int DEPTH = 8;
  logic clock = 0, Rst = 0;
  logic [1:0] req_valid = 0, req_ready;
  logic [7:0] req_data0 = 0, req_data1 = 0, tx_data;
  logic tx_busy = 0, irq_en = 0, irq_clr = 0, tx_start, irq;
  logic [$clog2(DEPTH):0] fifo_count;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic mlast = 0, mirq = 0;
  logic [7:0] mdata = 0;
  int mph = 0, eng = 0;
  bit auto_busy = 1;
  logic [1:0] last_er;
  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clock(clock), .Rst(Rst), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .irq_en(irq_en), .irq_clr(irq_clr), .irq(irq), .fifo_count(fifo_count)
  );
  always #5 clock = ~clock;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock cycle: check outputs against the model, advance the model, cross the edge.
  task automatic step();
    logic [1:0] er;
    int g, nph;
    bit b;
    if (auto_busy) tx_busy = eng > 0;
    #1;
    g = (req_valid == 2'b11) ? int'(!mlast) : int'(req_valid[1]);
    er = (q.size() == DEPTH || req_valid == 2'b00) ? 2'b00 : 2'(1 << g);
    chk("req_ready", req_ready, er);
    chk("tx_start", tx_start, mph == 1);
    chk("fifo_count", fifo_count, q.size());
    chk("irq", irq, mirq);
    chk("tx_data", tx_data, mdata);
    b = tx_busy;
    if (mph == 0 && q.size() > 0) begin
      mdata = q.pop_front();
      nph = 1;
    end else nph = (mph == 1) ? 2 : (mph == 2) ? (b ? 3 : 2) : (mph == 3) ? (b ? 3 : 0) : 0;
    if (er != 0) begin
      q.push_back(er[1] ? req_data1 : req_data0);
      mlast = er[1];
    end
    mirq = (mph == 3 && !b && irq_en && q.size() == 0) || (mirq && !irq_clr);
    eng = (mph == 1) ? 3 : (eng > 0) ? eng - 1 : 0;
    mph = nph;
    last_er = er;
    @(posedge clock);
    #1;
  endtask
  task automatic reset_check();
    req_valid = 2'b11;
    Rst = 1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_data", tx_data, 0);
    q.delete();
    mlast = 0; mph = 0; mdata = 0; mirq = 0; eng = 0;
    @(posedge clock);
    #1;
    Rst = 0;
    req_valid = 0;
  endtask
  initial begin
    int na, nb;
    #2;
    reset_check();
    // single CPU byte, engine busy for 3 cycles after launch
    req_valid = 2'b01; req_data0 = 8'h41;
    step();
    req_valid = 0;
    step();
    chk("launch_2cyc", tx_start, 1);
    chk("launch_data", tx_data, 8'h41);
    repeat (10) step();
    // tie arbitration and ordering
    na = 0; nb = 0;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_data0 = 8'hA0 + 8'(na);
      req_data1 = 8'hB0 + 8'(nb);
      step();
      chk("tie_grant", last_er, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (last_er[0]) na++;
      if (last_er[1]) nb++;
    end
    req_valid = 0;
    repeat (40) step();
    // fill with the engine stuck busy
    auto_busy = 0; tx_busy = 1; req_valid = 2'b01;
    for (int i = 0; i < DEPTH + 2; i++) begin
      req_data0 = 8'h10 + 8'(i);
      step();
    end
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", req_ready, 0);
    // pop and push offered while full
    tx_busy = 0; req_data0 = 8'h77;
    step();
    step();
    chk("pop_full_count", fifo_count, DEPTH - 1);
    step();
    chk("refill_count", fifo_count, DEPTH);
    req_valid = 0; auto_busy = 1; eng = 3;
    repeat (90) step();
    chk("drained", fifo_count, 0);
    // drain interrupt after the second byte, clear coincident with set
    irq_en = 1; req_valid = 2'b01;
    req_data0 = 8'h55; step();
    req_data0 = 8'h66; step();
    req_valid = 0;
    for (int i = 0; i < 30; i++) begin
      irq_clr = (mph == 3 && eng == 0);
      step();
    end
    irq_clr = 0;
    chk("irq_set_wins", irq, 1);
    irq_en = 0;
    step();
    chk("irq_hold_en0", irq, 1);
    // asynchronous reset in WAIT_DONE with bytes queued
    auto_busy = 0; tx_busy = 1; req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      req_data0 = 8'hC0 + 8'(i);
      step();
    end
    req_valid = 0;
    for (int i = 0; i < 10 && mph != 3; i++) step();
    chk("pre_rst_count", fifo_count, 3);
    reset_check();
    tx_busy = 0; auto_busy = 1;
    repeat (20) step();
    // interrupt clear on its own
    irq_en = 1; req_valid = 2'b10; req_data1 = 8'h5A;
    step();
    req_valid = 0;
    repeat (15) step();
    chk("irq_up", irq, 1);
    irq_en = 0; irq_clr = 1;
    step();
    irq_clr = 0;
    chk("irq_cleared", irq, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = 8'($urandom);
      req_data1 = 8'($urandom);
      irq_en = 1'($urandom_range(0, 1));
      irq_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, byte FIFO depth (power of two, 2..32).
REQ-002 SHALL have port clock  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port Rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  byte offered by requester i (0 = CPU, 1 = debug).
REQ-005 SHALL have port req_data0  input  8  requester 0 byte.
REQ-006 SHALL have port req_data1  input  8  requester 1 byte.
REQ-007 SHALL have port req_ready  output  2  grant to requester i; transfer when req_valid[i] & req_ready[i].
REQ-008 SHALL have port tx_start  output  1  one-cycle launch pulse to the UART TX engine.
REQ-009 SHALL have port tx_data  output  8  byte to transmit, registered, stable from tx_start until the next launch.
REQ-010 SHALL have port tx_busy  input  1  high while the TX engine sends start/data/stop bits.
REQ-011 SHALL have port irq_en  input  1  enable for the drain interrupt.
REQ-012 SHALL have port irq_clr  input  1  clear for the drain interrupt.
REQ-013 SHALL have port irq  output  1  sticky interrupt, set when the FIFO has drained.
REQ-014 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL push at most one byte per cycle into the FIFO, and only when fifo_count < DEPTH at the start of the cycle.
REQ-016 SHALL drive req_ready combinationally: both bits 0 when the FIFO is full; otherwise a single valid requester is granted.
REQ-017 SHALL grant the requester not granted last when both are valid; last_grant SHALL update only on an accepted push, reset value 0 (first tie goes to requester 1).
REQ-018 SHALL never assert both req_ready bits in the same cycle; a requester with req_valid low SHALL see req_ready low.
REQ-019 SHALL implement sequencer states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: if fifo_count != 0, pop the head into tx_data and go to LAUNCH; otherwise stay in IDLE.
REQ-021 LAUNCH: assert tx_start for exactly this cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: go to WAIT_DONE when tx_busy = 1.
REQ-023 WAIT_DONE: go to IDLE when tx_busy = 0.
REQ-024 SHALL take 2 cycles from a push into an empty FIFO with the sequencer in IDLE to tx_start (push edge, pop edge, then LAUNCH cycle).
REQ-025 SHALL allow a push and a pop in the same cycle (fifo_count unchanged), except that no push is accepted when the FIFO is full, even in a pop cycle.
REQ-026 SHALL keep the FIFO order: bytes leave in exact acceptance order; read and write pointers wrap modulo DEPTH.
REQ-027 SHALL set irq on the WAIT_DONE->IDLE transition when the FIFO is empty after that edge's updates and irq_en = 1.
REQ-028 SHALL hold irq until an irq_clr cycle; if set and clear coincide, set SHALL win.
REQ-029 SHALL clear irq when irq_clr is asserted, irrespective of irq_en; deasserting irq_en SHALL not clear a pending irq.

Reset
REQ-030 SHALL, on Rst high (asynchronously, without a clock), force: state IDLE, FIFO empty with pointers 0, fifo_count 0, tx_start 0, tx_data 8'h00, irq 0, last_grant 0.
REQ-031 SHALL hold req_ready at 0 while Rst is high.
REQ-032 SHALL discard any byte in flight when Rst asserts mid-transfer; the TX engine is reset by the same Rst.

Verification
REQ-033 SHALL cover: req_valid=01, req_data0=8'h41, tx_busy pulsed high 3 cycles after tx_start -> tx_start exactly once, 2 cycles after the push; tx_data=8'h41; returns to IDLE.
REQ-034 SHALL cover: req_valid=11 held for 4 accepted pushes (req0 bytes 8'hA0.., req1 bytes 8'hB0..) -> grants 1,0,1,0; FIFO order B0,A0,B1,A1.
REQ-035 SHALL cover: tx_busy held high, DEPTH+2 pushes attempted -> fifo_count saturates at DEPTH; req_ready=00 while full; no byte is lost or duplicated.
REQ-036 SHALL cover: FIFO full, pop and push offered in the same cycle -> push refused that cycle and accepted the next; fifo_count goes DEPTH -> DEPTH-1 -> DEPTH.
REQ-037 SHALL cover: irq_en=1, 2 bytes sent -> irq set after the second WAIT_DONE exit only; irq_clr coincident with a set -> irq stays 1.
REQ-038 SHALL cover: Rst asserted in WAIT_DONE with 3 bytes queued -> fifo_count=0, irq=0, tx_start=0 immediately; no further tx_start until a new push.
